// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Captures register-file read data, immediate and decoded control from ID and
// presents them to EX one cycle later. Also owns the WB->ID write-through
// (the register file writes on the edge but reads combinationally), load-use
// hazard detection with bubble insertion, and flush/hold sequencing.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    // ID-stage instruction
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,

    // WB write port (same signals that drive the register file)
    input  logic            wb_reg_write,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_wd,

    // Pipeline control
    input  logic            flush,
    input  logic            hold,
    output logic            stall,

    // EX-stage view
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg
);

    // ------------------------------------------------------------------
    // Registered EX state and its next-state values
    // ------------------------------------------------------------------
    logic            valid_q,      valid_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [XLEN-1:0] op1_q,        op1_d;
    logic [XLEN-1:0] op2_q,        op2_d;
    logic [XLEN-1:0] imm_q,        imm_d;
    logic [AW-1:0]   rs1_q,        rs1_d;
    logic [AW-1:0]   rs2_q,        rs2_d;
    logic [AW-1:0]   rd_q,         rd_d;
    logic [3:0]      alu_op_q,     alu_op_d;
    logic            alu_src_q,    alu_src_d;
    logic            mem_read_q,   mem_read_d;
    logic            mem_write_q,  mem_write_d;
    logic            reg_write_q,  reg_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;

    // Combinational helpers
    logic [XLEN-1:0] op1_n;
    logic [XLEN-1:0] op2_n;
    logic            rs1_dep;
    logic            rs2_dep;
    logic            hazard;
    logic            do_bubble;
    logic            do_load;

    // Operand select: x0 reads as zero, otherwise take the value WB is
    // writing this very edge in preference to the stale register-file read.
    always_comb begin
        op1_n = id_rd1;
        if (id_rs1 == '0) begin
            op1_n = '0;
        end else if (wb_reg_write && (wb_rd == id_rs1)) begin
            op1_n = wb_wd;
        end

        op2_n = id_rd2;
        if (id_rs2 == '0) begin
            op2_n = '0;
        end else if (wb_reg_write && (wb_rd == id_rs2)) begin
            op2_n = wb_wd;
        end
    end

    // Load-use detection against the load currently sitting in EX; a load
    // into x0 never produces a usable value, so it never stalls anyone.
    always_comb begin
        rs1_dep = id_uses_rs1 && (id_rs1 == rd_q);
        rs2_dep = id_uses_rs2 && (id_rs2 == rd_q);
        hazard  = id_valid && valid_q && mem_read_q && (rd_q != '0)
                  && (rs1_dep || rs2_dep);
    end

    // Flush overrides everything so IF is free to redirect.
    assign stall = !flush && (hold || hazard);

    // Edge action selection: flush > hold > hazard > load.
    always_comb begin
        do_bubble = flush || (!hold && hazard);
        do_load   = !flush && !hold && !hazard;
    end

    // Next-state: keep by default (hold), clear on bubble, capture on load.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        alu_op_d     = alu_op_q;
        alu_src_d    = alu_src_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;

        if (do_bubble) begin
            // Clear every field so a bubble is deterministic and its rd
            // (x0) can never match in the forwarding unit.
            valid_d      = 1'b0;
            pc_d         = '0;
            op1_d        = '0;
            op2_d        = '0;
            imm_d        = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            alu_op_d     = '0;
            alu_src_d    = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (do_load) begin
            valid_d      = id_valid;
            pc_d         = id_pc;
            op1_d        = op1_n;
            op2_d        = op2_n;
            imm_d        = id_imm;
            rs1_d        = id_rs1;
            rs2_d        = id_rs2;
            rd_d         = id_rd;
            alu_op_d     = id_alu_op;
            alu_src_d    = id_alu_src;
            mem_to_reg_d = id_mem_to_reg;
            // An empty ID slot may carry junk decode; strip the bits that
            // would have architectural side effects.
            mem_read_d   = id_valid && id_mem_read;
            mem_write_d  = id_valid && id_mem_write;
            reg_write_d  = id_valid && id_reg_write;
        end
    end

    // EX state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            alu_op_q     <= alu_op_d;
            alu_src_q    <= alu_src_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Outputs come straight from registers: no id_* -> ex_* comb path.
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_op1        = op1_q;
    assign ex_op2        = op2_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_alu_src    = alu_src_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reset prelude, then a cycle-by-cycle
// vector table whose expected EX contents go through a scoreboard queue.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid, id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [AW-1:0]   id_rs1, id_rs2, id_rd;
    logic [3:0]      id_alu_op;
    logic            id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic            wb_reg_write;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_wd;
    logic            flush, hold, stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [AW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_alu_op;
    logic            ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

    id_ex_stage #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        // stimulus
        logic            flush, hold, valid, u1, u2;
        logic [XLEN-1:0] pc, rd1, rd2, imm;
        logic [AW-1:0]   rs1, rs2, rd;
        logic [3:0]      op;
        logic            asrc, mr, mw, rw, m2r;
        logic            wbw;
        logic [AW-1:0]   wbrd;
        logic [XLEN-1:0] wbwd;
        // expected
        logic            e_stall, e_valid;
        logic [XLEN-1:0] e_pc, e_op1, e_op2, e_imm;
        logic [AW-1:0]   e_rs1, e_rs2, e_rd;
        logic [3:0]      e_op;
        logic            e_asrc, e_mr, e_mw, e_rw, e_m2r;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row=%0d %s: got 0x%0h, want 0x%0h", idx, nm, act, exp);
        end
    endtask

    function automatic vec_t nop();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        flush = v.flush;         hold = v.hold;
        id_valid = v.valid;      id_pc = v.pc;
        id_rs1 = v.rs1;          id_rs2 = v.rs2;          id_rd = v.rd;
        id_uses_rs1 = v.u1;      id_uses_rs2 = v.u2;
        id_rd1 = v.rd1;          id_rd2 = v.rd2;          id_imm = v.imm;
        id_alu_op = v.op;        id_alu_src = v.asrc;
        id_mem_read = v.mr;      id_mem_write = v.mw;
        id_reg_write = v.rw;     id_mem_to_reg = v.m2r;
        wb_reg_write = v.wbw;    wb_rd = v.wbrd;          wb_wd = v.wbwd;
    endtask

    task automatic compare_ex(input int idx, input vec_t e);
        check(idx, "ex_valid",      32'(ex_valid),      32'(e.e_valid));
        check(idx, "ex_pc",         ex_pc,              e.e_pc);
        check(idx, "ex_op1",        ex_op1,             e.e_op1);
        check(idx, "ex_op2",        ex_op2,             e.e_op2);
        check(idx, "ex_imm",        ex_imm,             e.e_imm);
        check(idx, "ex_rs1",        32'(ex_rs1),        32'(e.e_rs1));
        check(idx, "ex_rs2",        32'(ex_rs2),        32'(e.e_rs2));
        check(idx, "ex_rd",         32'(ex_rd),         32'(e.e_rd));
        check(idx, "ex_alu_op",     32'(ex_alu_op),     32'(e.e_op));
        check(idx, "ex_alu_src",    32'(ex_alu_src),    32'(e.e_asrc));
        check(idx, "ex_mem_read",   32'(ex_mem_read),   32'(e.e_mr));
        check(idx, "ex_mem_write",  32'(ex_mem_write),  32'(e.e_mw));
        check(idx, "ex_reg_write",  32'(ex_reg_write),  32'(e.e_rw));
        check(idx, "ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.e_m2r));
    endtask

    initial begin
        vec_t v;
        vec_t e;

        // ---------------- vector table ----------------
        // 0: addi x2, x1, 3 (x1 = 5)
        v = nop(); v.valid = 1; v.pc = 32'h100; v.rs1 = 1; v.u1 = 1; v.rd1 = 5; v.rd = 2;
        v.imm = 3; v.asrc = 1; v.rw = 1;
        v.e_valid = 1; v.e_pc = 32'h100; v.e_op1 = 5; v.e_imm = 3; v.e_rs1 = 1; v.e_rd = 2;
        v.e_asrc = 1; v.e_rw = 1; tbl.push_back(v);
        // 1: write-through of x7 from WB
        v = nop(); v.valid = 1; v.pc = 32'h104; v.rs1 = 7; v.u1 = 1; v.rd1 = 32'h11;
        v.rs2 = 3; v.u2 = 1; v.rd2 = 32'h22; v.rd = 4; v.rw = 1; v.op = 4'h2;
        v.wbw = 1; v.wbrd = 7; v.wbwd = 32'hABCD;
        v.e_valid = 1; v.e_pc = 32'h104; v.e_op1 = 32'hABCD; v.e_op2 = 32'h22; v.e_rs1 = 7;
        v.e_rs2 = 3; v.e_rd = 4; v.e_rw = 1; v.e_op = 4'h2; tbl.push_back(v);
        // 2: WB writing x0 never reaches the operand
        v = nop(); v.valid = 1; v.pc = 32'h108; v.rs1 = 0; v.u1 = 1; v.rd1 = 32'h55; v.rd = 4; v.rw = 1;
        v.wbw = 1; v.wbrd = 0; v.wbwd = 32'hFFFF;
        v.e_valid = 1; v.e_pc = 32'h108; v.e_op1 = 0; v.e_rd = 4; v.e_rw = 1; tbl.push_back(v);
        // 3: lw x5, 8(x1)
        v = nop(); v.valid = 1; v.pc = 32'h10C; v.rs1 = 1; v.u1 = 1; v.rd1 = 32'h200; v.imm = 8;
        v.rd = 5; v.mr = 1; v.rw = 1; v.m2r = 1; v.asrc = 1;
        v.e_valid = 1; v.e_pc = 32'h10C; v.e_op1 = 32'h200; v.e_imm = 8; v.e_rs1 = 1; v.e_rd = 5;
        v.e_mr = 1; v.e_rw = 1; v.e_m2r = 1; v.e_asrc = 1; tbl.push_back(v);
        // 4,5: add x6, x5, x1 -> one bubble, then loads
        for (int k = 0; k < 2; k++) begin
            v = nop(); v.valid = 1; v.pc = 32'h110; v.rs1 = 5; v.u1 = 1; v.rs2 = 1; v.u2 = 1;
            v.rd1 = 1; v.rd2 = 2; v.rd = 6; v.rw = 1;
            if (k == 0) begin
                v.e_stall = 1;
            end else begin
                v.e_valid = 1; v.e_pc = 32'h110; v.e_op1 = 1; v.e_op2 = 2; v.e_rs1 = 5;
                v.e_rs2 = 1; v.e_rd = 6; v.e_rw = 1;
            end
            tbl.push_back(v);
        end
        // 6: lw x0
        v = nop(); v.valid = 1; v.rs1 = 1; v.u1 = 1; v.rd1 = 32'h300; v.rd = 0; v.mr = 1; v.rw = 1; v.m2r = 1;
        v.e_valid = 1; v.e_op1 = 32'h300; v.e_rs1 = 1; v.e_mr = 1; v.e_rw = 1; v.e_m2r = 1; tbl.push_back(v);
        // 7: dependent on x0 -> no stall
        v = nop(); v.valid = 1; v.rs1 = 0; v.u1 = 1; v.rs2 = 2; v.u2 = 1; v.rd2 = 9; v.rd = 7; v.rw = 1;
        v.e_valid = 1; v.e_op2 = 9; v.e_rs2 = 2; v.e_rd = 7; v.e_rw = 1; tbl.push_back(v);
        // 8: lw x6
        v = nop(); v.valid = 1; v.rs1 = 2; v.u1 = 1; v.rd1 = 32'h40; v.rd = 6; v.mr = 1; v.rw = 1; v.m2r = 1;
        v.e_valid = 1; v.e_op1 = 32'h40; v.e_rs1 = 2; v.e_rd = 6; v.e_mr = 1; v.e_rw = 1; v.e_m2r = 1;
        tbl.push_back(v);
        // 9: addresses match x6 but neither source is used -> no stall
        v = nop(); v.valid = 1; v.rs1 = 6; v.rs2 = 6; v.rd1 = 32'h77; v.rd2 = 32'h66; v.rd = 8;
        v.imm = 7; v.rw = 1; v.asrc = 1;
        v.e_valid = 1; v.e_op1 = 32'h77; v.e_op2 = 32'h66; v.e_rs1 = 6; v.e_rs2 = 6; v.e_rd = 8;
        v.e_imm = 7; v.e_rw = 1; v.e_asrc = 1; tbl.push_back(v);
        // 10: lw x7
        v = nop(); v.valid = 1; v.rs1 = 1; v.u1 = 1; v.rd1 = 32'h10; v.rd = 7; v.mr = 1; v.rw = 1; v.m2r = 1;
        v.e_valid = 1; v.e_op1 = 32'h10; v.e_rs1 = 1; v.e_rd = 7; v.e_mr = 1; v.e_rw = 1; v.e_m2r = 1;
        tbl.push_back(v);
        // 11: hazard + hold + flush -> flush wins, stall 0, bubble
        v = nop(); v.valid = 1; v.rs2 = 7; v.u2 = 1; v.rd = 9; v.rw = 1; v.hold = 1; v.flush = 1;
        tbl.push_back(v);
        // 12: invalid ID with side-effect bits set
        v = nop(); v.valid = 0; v.pc = 32'h200; v.rs1 = 3; v.rd1 = 32'h33; v.rd = 10; v.imm = 32'h44;
        v.op = 4'h5; v.rw = 1; v.mw = 1;
        v.e_pc = 32'h200; v.e_op1 = 32'h33; v.e_rs1 = 3; v.e_rd = 10; v.e_imm = 32'h44; v.e_op = 4'h5;
        tbl.push_back(v);
        // 13: instruction that will be held
        v = nop(); v.valid = 1; v.pc = 32'h300; v.rs1 = 2; v.u1 = 1; v.rd1 = 32'hAA; v.rd = 11; v.rw = 1; v.op = 4'h3;
        v.e_valid = 1; v.e_pc = 32'h300; v.e_op1 = 32'hAA; v.e_rs1 = 2; v.e_rd = 11; v.e_rw = 1; v.e_op = 4'h3;
        tbl.push_back(v);
        // 14-16: hold for 3 cycles while ID keeps changing
        for (int k = 0; k < 3; k++) begin
            e = v;
            e.hold = 1; e.pc = 32'h304 + 32'(k); e.rs1 = 4; e.rd1 = 32'hB0 + 32'(k); e.rd = 12;
            e.wbw = 1; e.wbrd = 2; e.wbwd = 32'h1234;
            e.e_stall = 1;
            tbl.push_back(e);
        end
        // 17: first edge after hold drops, with write-through of x4
        v = nop(); v.valid = 1; v.pc = 32'h310; v.rs1 = 4; v.u1 = 1; v.rd1 = 32'hCC; v.rd = 12; v.rw = 1;
        v.wbw = 1; v.wbrd = 4; v.wbwd = 32'hDEAD;
        v.e_valid = 1; v.e_pc = 32'h310; v.e_op1 = 32'hDEAD; v.e_rs1 = 4; v.e_rd = 12; v.e_rw = 1;
        tbl.push_back(v);
        // 18: lw x3
        v = nop(); v.valid = 1; v.rs1 = 1; v.u1 = 1; v.rd1 = 8; v.rd = 3; v.mr = 1; v.rw = 1; v.m2r = 1;
        v.e_valid = 1; v.e_op1 = 8; v.e_rs1 = 1; v.e_rd = 3; v.e_mr = 1; v.e_rw = 1; v.e_m2r = 1;
        tbl.push_back(v);
        // 19,20: lw x4, 0(x3) -> one bubble, then loads
        for (int k = 0; k < 2; k++) begin
            v = nop(); v.valid = 1; v.rs1 = 3; v.u1 = 1; v.rd1 = 9; v.rd = 4; v.mr = 1; v.rw = 1; v.m2r = 1;
            if (k == 0) v.e_stall = 1;
            else begin
                v.e_valid = 1; v.e_op1 = 9; v.e_rs1 = 3; v.e_rd = 4; v.e_mr = 1; v.e_rw = 1; v.e_m2r = 1;
            end
            tbl.push_back(v);
        end
        // 21,22: add x5, x0, x4 (rs2 dependency) -> one bubble, then loads
        for (int k = 0; k < 2; k++) begin
            v = nop(); v.valid = 1; v.rs2 = 4; v.u2 = 1; v.rd2 = 5; v.rd = 5; v.rw = 1;
            if (k == 0) v.e_stall = 1;
            else begin
                v.e_valid = 1; v.e_op2 = 5; v.e_rs2 = 4; v.e_rd = 5; v.e_rw = 1;
            end
            tbl.push_back(v);
        end

        // ---------------- reset prelude ----------------
        apply(nop());
        repeat (2) @(negedge clk);
        e = nop();
        compare_ex(-1, e);
        // addi presented during reset must not load
        v = tbl[0];
        apply(v);
        @(posedge clk); #1;
        check(-1, "rst_hold_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check(-2, "post_rst_valid", 32'(ex_valid), 32'd1);
        check(-2, "post_rst_op1",   ex_op1,        32'd5);
        check(-2, "post_rst_imm",   ex_imm,        32'd3);
        // asynchronous assertion mid-cycle clears immediately
        #1 rst_n = 1'b0;
        #1;
        compare_ex(-3, e);
        @(negedge clk);
        apply(nop());
        rst_n = 1'b1;

        // ---------------- table run with scoreboard ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check(i, "stall", 32'(stall), 32'(tbl[i].e_stall));
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                bad++;
                total++;
                $display("FAIL row=%0d scoreboard: got empty queue, want one entry", i);
            end else begin
                e = exp_q.pop_front();
                compare_ex(i, e);
            end
            $display("vec %0d: stall=%0b ex_valid=%0b ex_pc=%0h ex_op1=%0h ex_op2=%0h ex_rd=%0d",
                     i, tbl[i].e_stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage RISC-V core. It sits directly downstream of the register file and decode logic. Each cycle it captures the register-file read data (rd1/rd2), the immediate and the decoded control bits, and presents them to the EX stage. It also owns three related functions:
- WB→ID write-through, since the register file writes on the clock edge and reads combinationally.
- Load-use hazard detection and bubble insertion.
- Flush and hold handling.

## Interface
Parameters
- XLEN, 32, datapath width
- AW, 5, register address width

Ports
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  AW  register addresses
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rd1, id_rd2  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  4  ALU operation code
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  decoded control
- wb_reg_write  in  1  WB write enable (same signal as the register-file write port)
- wb_rd  in  AW  WB write address
- wb_wd  in  XLEN  WB write data
- flush  in  1  EX branch/jump redirect; kill the ID instruction
- hold  in  1  downstream (MEM) busy; freeze this stage
- stall  out  1  freeze PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN  registered PC, operands and immediate
- ex_rs1, ex_rs2, ex_rd  out  AW  registered addresses, for the forwarding unit
- ex_alu_op  out  4  registered ALU operation
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered control

## Operation

**Operand select (combinational)**
- op1_n = 0 if id_rs1 == 0.
- Otherwise op1_n = wb_wd if wb_reg_write && wb_rd == id_rs1.
- Otherwise op1_n = id_rd1.
- op2_n is formed the same way from id_rs2 and id_rd2.

**Load-use hazard (combinational, from current EX registers)**
- hazard = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).

**stall output (combinational)**
- stall = !flush && (hold || hazard).

**Per-edge update, in priority order**
1. rst_n low: all outputs go to 0, asynchronously.
2. flush: bubble.
3. hold: all ex_* registers keep their values.
4. hazard: bubble; the ID instruction is re-presented next cycle because stall froze IF/ID.
5. Otherwise load:
   - ex_valid ← id_valid.
   - ex_op1/ex_op2 ← op1_n/op2_n.
   - All other ex_* fields ← their id_* counterparts.
   - If id_valid = 0, the fields still load but ex_reg_write, ex_mem_read and ex_mem_write are forced to 0.

**Bubble**
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg = 0.
- All other data/address fields are cleared to 0 (deterministic, and x0 never forwards).

**Write-through under hold**
- While hold is asserted, WB may still retire. Write-through applies only on the loading edge; a held EX instruction relies on the forwarding unit, not this block.

**Boundary cases**
- x0: write-through never applies, even if wb_rd == 0 with wb_reg_write = 1; the operand is 0.
- Load with rd = x0 followed by a dependent instruction: no hazard.
- Instruction with uses_rsX = 0 and a matching address: no hazard.
- flush together with hazard or hold: flush wins and stall = 0, so IF can redirect.
- Back-to-back load-use: exactly one bubble per dependency.

## Timing
- Latency: 1 cycle, ID → EX, registered on the rising clk edge.
- stall, hazard and op1_n/op2_n are same-cycle combinational; there is no combinational path from id_* to ex_*.
- Reset: asynchronous assert, release synchronous to clk. Outputs read 0 from assertion until the first loading edge after release.
- Reset mid-operation discards the in-flight EX instruction; no partial state is retained.
- Throughput: 1 instruction/cycle without hazards. A load-use costs exactly 1 bubble cycle. Hold costs 1 cycle per held cycle.

## Test plan
1. **Reset and basic flow.** Assert rst_n = 0 mid-stream, release, then present addi with rs1 = 1 (id_rd1 = 5) and id_imm = 3. Required: all outputs 0 during reset; next edge gives ex_valid = 1, ex_op1 = 5, ex_imm = 3.
2. **Write-through.** id_rs1 = 7, id_rd1 = 0x11, wb_reg_write = 1, wb_rd = 7, wb_wd = 0xABCD. Required: ex_op1 = 0xABCD. Repeat with rs1 = wb_rd = 0 and wb_wd = 0xFFFF. Required: ex_op1 = 0.
3. **Load-use.** lw x5 in EX, then add x6, x5, x1 in ID. Required: stall = 1 for one cycle, one bubble (ex_valid = 0, ex_reg_write = 0), then add loads next cycle with stall = 0. Same sequence with lw x0: no stall.
4. **Flush priority.** Load-use hazard and hold both active, plus flush = 1. Required: stall = 0 and a bubble in EX.
5. **Hold.** hold = 1 for 3 cycles while ID changes. Required: ex_* unchanged for 3 edges, stall = 1 throughout, then the ID instruction loads on the first edge after hold drops.
6. **Invalid ID.** id_valid = 0 with id_reg_write = 1 and id_mem_write = 1. Required: ex_valid = 0, ex_reg_write = 0, ex_mem_write = 0.
